// File: rtl/clk_div_prog.sv
// clk_div_prog
//   Multi-channel programmable clock divider. Every channel produces a
//   registered 50%-duty square wave (clk_out) and a one-cycle strobe (tick)
//   on each 0->1 edge of clk_out. Both are meant to be used as enables in
//   the clk domain. Each channel's half-period can be reprogrammed at run
//   time. A new value is held pending and loaded only at the high->low
//   toggle, or on the next cycle if the channel is disabled. Because of
//   this, no period ever mixes old and new phase lengths.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   en         per-channel run enable
//   cfg_valid  configuration write request
//   cfg_ready  write accepted when cfg_valid && cfg_ready (combinational)
//   cfg_ch     target channel of the write
//   cfg_half   new half-period in clk cycles (0 is treated as 1)
//   cfg_err    one-cycle pulse after a write to a channel index >= CHANNELS
//   clk_out    divided square wave per channel
//   tick       one-cycle strobe per channel on each rising clk_out edge
module clk_div_prog #(
    parameter  int CHANNELS     = 4,
    parameter  int CNT_W        = 24,
    parameter  int DEFAULT_HALF = 50000,
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_half,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [CNT_W-1:0] HALF_RST =
        (DEFAULT_HALF < 1) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0]    cnt      [CHANNELS];
    logic [CNT_W-1:0]    half     [CHANNELS];
    logic [CNT_W-1:0]    pend_val [CHANNELS];
    logic [CHANNELS-1:0] pend;

    logic [CHANNELS-1:0] wr;
    logic                ch_hit;
    logic                accept;
    logic [CNT_W-1:0]    half_c;

    // Channel decode. An index that matches no channel keeps cfg_ready high,
    // so writes to a nonexistent channel are consumed and flagged, not stalled.
    always_comb begin
        cfg_ready = 1'b1;
        ch_hit    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend[i];
                ch_hit    = 1'b1;
            end
        end
    end

    assign accept = cfg_valid && cfg_ready;
    assign half_c = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

    always_comb begin
        wr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr[i] = accept && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !ch_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]      <= '0;
                half[i]     <= HALF_RST;
                pend_val[i] <= HALF_RST;
                pend[i]     <= 1'b0;
                clk_out[i]  <= 1'b0;
                tick[i]     <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                tick[i] <= 1'b0;
                if (!en[i]) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    if (pend[i]) begin
                        half[i] <= pend_val[i];
                        pend[i] <= 1'b0;
                    end
                end else if (cnt[i] == half[i] - CNT_W'(1)) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= ~clk_out[i];
                    tick[i]    <= ~clk_out[i];
                    // Only the high->low toggle closes a full period.
                    if (clk_out[i] && pend[i]) begin
                        half[i] <= pend_val[i];
                        pend[i] <= 1'b0;
                    end
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                // A write is only accepted while pend is clear, so it never
                // collides with the load above. A write that arrives on a
                // boundary therefore waits for the next boundary.
                if (wr[i]) begin
                    pend_val[i] <= half_c;
                    pend[i]     <= 1'b1;
                end
            end
        end
    end

endmodule
